// File: rtl/combo_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : combo_lock_ctrl
// Brief    : Digit-by-digit combination lock sequencer with timed unlock
//            window and lockout after repeated failed entries.
// Revision : 1.0 - initial release
// ============================================================================
module combo_lock_ctrl #(
    parameter int CODE_LEN       = 4,
    parameter int KEY_W          = 2,
    parameter int MAX_TRIES      = 3,
    parameter int UNLOCK_CYCLES  = 8,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      btn_valid,
    input  logic [KEY_W-1:0]          btn_code,
    input  logic [CODE_LEN*KEY_W-1:0] code_word,
    input  logic                      clear_entry,
    input  logic                      relock,
    output logic                      unlocked,
    output logic                      error,
    output logic                      locked_out,
    output logic [3:0]                digit_count,
    output logic [3:0]                fail_count
);

    localparam logic [1:0]  c_ST_ENTRY   = 2'd0;
    localparam logic [1:0]  c_ST_OPEN    = 2'd1;
    localparam logic [1:0]  c_ST_LOCKOUT = 2'd2;

    localparam logic [3:0]  c_LAST_DIGIT = 4'(CODE_LEN - 1);
    localparam logic [4:0]  c_MAX_TRIES  = 5'(MAX_TRIES);
    localparam logic [15:0] c_UNLOCK     = 16'(UNLOCK_CYCLES);
    localparam logic [15:0] c_LOCKOUT    = 16'(LOCKOUT_CYCLES);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_mismatch;
    logic             w_mismatch_nxt;
    logic [15:0]      r_timer;
    logic [15:0]      w_timer_nxt;
    logic [3:0]       r_digit_count;
    logic [3:0]       w_digit_count_nxt;
    logic [3:0]       r_fail_count;
    logic [3:0]       w_fail_count_nxt;
    logic             r_unlocked;
    logic             w_unlocked_nxt;
    logic             r_error;
    logic             w_error_nxt;
    logic             r_locked_out;
    logic             w_locked_out_nxt;

    logic [KEY_W-1:0] w_expected_digit;
    logic             w_press;
    logic             w_final_digit;
    logic             w_final_fail;
    logic             w_tries_exhausted;
    logic             w_timer_last;
    logic [15:0]      w_timer_dec;

    // code_word is read at the press edge, so late edits only affect later digits
    assign w_expected_digit  = code_word[int'(r_digit_count) * KEY_W +: KEY_W];
    assign w_press           = btn_valid && !clear_entry;
    assign w_final_digit     = (r_digit_count == c_LAST_DIGIT);
    assign w_final_fail      = r_mismatch || (btn_code != w_expected_digit);
    assign w_tries_exhausted = (({1'b0, r_fail_count} + 5'd1) >= c_MAX_TRIES);
    assign w_timer_last      = (r_timer == 16'd1);
    assign w_timer_dec       = (r_timer != 16'd0) ? (r_timer - 16'd1) : 16'd0;

    // ------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_ENTRY;
            r_mismatch    <= 1'b0;
            r_timer       <= 16'd0;
            r_digit_count <= 4'd0;
            r_fail_count  <= 4'd0;
            r_unlocked    <= 1'b0;
            r_error       <= 1'b0;
            r_locked_out  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_mismatch    <= w_mismatch_nxt;
            r_timer       <= w_timer_nxt;
            r_digit_count <= w_digit_count_nxt;
            r_fail_count  <= w_fail_count_nxt;
            r_unlocked    <= w_unlocked_nxt;
            r_error       <= w_error_nxt;
            r_locked_out  <= w_locked_out_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_mismatch_nxt    = r_mismatch;
        w_timer_nxt       = r_timer;
        w_digit_count_nxt = r_digit_count;
        w_fail_count_nxt  = r_fail_count;

        case (r_state)
            c_ST_ENTRY: begin
                if (clear_entry) begin
                    w_digit_count_nxt = 4'd0;
                    w_mismatch_nxt    = 1'b0;
                end else if (btn_valid) begin
                    if (!w_final_digit) begin
                        w_mismatch_nxt    = w_final_fail;
                        w_digit_count_nxt = r_digit_count + 4'd1;
                    end else begin
                        w_digit_count_nxt = 4'd0;
                        w_mismatch_nxt    = 1'b0;
                        if (!w_final_fail) begin
                            w_state_nxt      = c_ST_OPEN;
                            w_fail_count_nxt = 4'd0;
                            w_timer_nxt      = c_UNLOCK;
                        end else if (w_tries_exhausted) begin
                            w_state_nxt      = c_ST_LOCKOUT;
                            w_fail_count_nxt = 4'd0;
                            w_timer_nxt      = c_LOCKOUT;
                        end else begin
                            w_fail_count_nxt = r_fail_count + 4'd1;
                        end
                    end
                end
            end

            c_ST_OPEN: begin
                w_timer_nxt = w_timer_dec;
                if (w_timer_last || relock) begin
                    w_state_nxt = c_ST_ENTRY;
                    w_timer_nxt = 16'd0;
                end
            end

            c_ST_LOCKOUT: begin
                w_timer_nxt = w_timer_dec;
                if (w_timer_last) begin
                    w_state_nxt = c_ST_ENTRY;
                    w_timer_nxt = 16'd0;
                end
            end

            default: begin
                w_state_nxt       = c_ST_ENTRY;
                w_mismatch_nxt    = 1'b0;
                w_timer_nxt       = 16'd0;
                w_digit_count_nxt = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (values registered alongside the state)
    // ------------------------------------------------------------------
    always_comb begin
        w_unlocked_nxt   = (w_state_nxt == c_ST_OPEN);
        w_locked_out_nxt = (w_state_nxt == c_ST_LOCKOUT);
        w_error_nxt      = (r_state == c_ST_ENTRY) && w_press
                           && w_final_digit && w_final_fail;
    end

    assign unlocked    = r_unlocked;
    assign error       = r_error;
    assign locked_out  = r_locked_out;
    assign digit_count = r_digit_count;
    assign fail_count  = r_fail_count;

endmodule
`default_nettype wire

// File: tb/tb_combo_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_combo_lock_ctrl
// Brief    : Scoreboard bench for combo_lock_ctrl with a transaction-level
//            reference model of the lock's modes and entry history.
// Revision : 1.0 - initial release
// ============================================================================
module tb_combo_lock_ctrl;

    localparam int CODE_LEN       = 4;
    localparam int KEY_W          = 2;
    localparam int MAX_TRIES      = 3;
    localparam int UNLOCK_CYCLES  = 8;
    localparam int LOCKOUT_CYCLES = 16;

    localparam int M_ENTRY   = 0;
    localparam int M_OPEN    = 1;
    localparam int M_LOCKOUT = 2;

    typedef struct {
        int unl;
        int err;
        int lo;
        int dc;
        int fc;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      btn_valid;
    logic [KEY_W-1:0]          btn_code;
    logic [CODE_LEN*KEY_W-1:0] code_word;
    logic                      clear_entry;
    logic                      relock;
    logic                      unlocked;
    logic                      error;
    logic                      locked_out;
    logic [3:0]                digit_count;
    logic [3:0]                fail_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    // reference model state: mode, per-digit match history, fails, cycles left
    int   m_mode  = M_ENTRY;
    bit   m_hits[$];
    int   m_fails = 0;
    int   m_left  = 0;
    int   m_err   = 0;

    combo_lock_ctrl #(
        .CODE_LEN       (CODE_LEN),
        .KEY_W          (KEY_W),
        .MAX_TRIES      (MAX_TRIES),
        .UNLOCK_CYCLES  (UNLOCK_CYCLES),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_valid   (btn_valid),
        .btn_code    (btn_code),
        .code_word   (code_word),
        .clear_entry (clear_entry),
        .relock      (relock),
        .unlocked    (unlocked),
        .error       (error),
        .locked_out  (locked_out),
        .digit_count (digit_count),
        .fail_count  (fail_count)
    );

    always #5 clk = ~clk;

    function automatic int code_digit(input int idx);
        int cw;
        cw = int'(code_word);
        return (cw >> (KEY_W * idx)) & ((1 << KEY_W) - 1);
    endfunction

    task automatic model_step(input bit bv, input int bc, input bit clr,
                              input bit rl, input bit rs);
        bit all_ok;
        m_err = 0;
        if (rs) begin
            m_mode  = M_ENTRY;
            m_hits.delete();
            m_fails = 0;
            m_left  = 0;
        end else if (m_mode == M_ENTRY) begin
            if (clr) begin
                m_hits.delete();
            end else if (bv) begin
                m_hits.push_back(bc == code_digit(m_hits.size()));
                if (m_hits.size() == CODE_LEN) begin
                    all_ok = 1'b1;
                    foreach (m_hits[i]) if (!m_hits[i]) all_ok = 1'b0;
                    m_hits.delete();
                    if (all_ok) begin
                        m_mode  = M_OPEN;
                        m_fails = 0;
                        m_left  = UNLOCK_CYCLES;
                    end else begin
                        m_err   = 1;
                        m_fails = m_fails + 1;
                        if (m_fails == MAX_TRIES) begin
                            m_mode  = M_LOCKOUT;
                            m_fails = 0;
                            m_left  = LOCKOUT_CYCLES;
                        end
                    end
                end
            end
        end else if (m_mode == M_OPEN) begin
            m_left = m_left - 1;
            if (m_left == 0 || rl) m_mode = M_ENTRY;
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) m_mode = M_ENTRY;
        end
    endtask

    task automatic cycle(input bit bv, input int bc, input bit clr,
                         input bit rl, input bit rs);
        exp_t e;
        btn_valid   = bv;
        btn_code    = KEY_W'(bc);
        clear_entry = clr;
        relock      = rl;
        reset       = rs;
        model_step(bv, bc, clr, rl, rs);
        e.unl = (m_mode == M_OPEN)    ? 1 : 0;
        e.err = m_err;
        e.lo  = (m_mode == M_LOCKOUT) ? 1 : 0;
        e.dc  = m_hits.size();
        e.fc  = m_fails;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
    endtask

    task automatic press(input int d);
        cycle(1, d, 0, 0, 0);
        idle(1);
    endtask

    task automatic enter4(input int a, input int b, input int c, input int d);
        press(a); press(b); press(c); press(d);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: one expected record per clock edge
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("unlocked",    int'(unlocked),    e.unl);
                chk("error",       int'(error),       e.err);
                chk("locked_out",  int'(locked_out),  e.lo);
                chk("digit_count", int'(digit_count), e.dc);
                chk("fail_count",  int'(fail_count),  e.fc);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int bv, bc, clr, rl, rs;
        code_word = 8'h8D;
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        idle(2);

        // correct code opens for the full window
        enter4(1, 3, 0, 2);
        idle(UNLOCK_CYCLES + 2);

        // one bad entry, then recovery
        enter4(1, 3, 0, 3);
        enter4(1, 3, 0, 2);
        idle(UNLOCK_CYCLES + 2);

        // three bad entries lock out; presses during lockout ignored
        enter4(0, 0, 0, 0);
        enter4(0, 0, 0, 0);
        enter4(0, 0, 0, 0);
        press(1); press(3);
        cycle(0, 0, 1, 1, 0);
        idle(LOCKOUT_CYCLES);
        enter4(1, 3, 0, 2);

        // early relock, with presses during OPEN
        idle(UNLOCK_CYCLES + 2);
        press(1); press(3); press(0); cycle(1, 2, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 3, 1, 0, 0);
        cycle(0, 0, 0, 1, 0);
        idle(2);

        // clear wins over a simultaneous press
        press(1); press(3);
        cycle(1, 0, 1, 0, 0);
        enter4(1, 3, 0, 2);
        idle(UNLOCK_CYCLES + 2);

        // reset in the middle of lockout
        enter4(0, 1, 2, 3);
        enter4(0, 1, 2, 3);
        enter4(3, 3, 3, 3);
        idle(4);
        cycle(0, 0, 0, 0, 1);
        enter4(1, 3, 0, 2);
        idle(UNLOCK_CYCLES + 2);

        // randomized phase, biased toward correct digits to reach OPEN often
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(99) < 2) code_word = CODE_LEN*KEY_W'($urandom);
            bv  = ($urandom_range(99) < 45) ? 1 : 0;
            bc  = ($urandom_range(99) < 75) ? code_digit(m_hits.size() % CODE_LEN)
                                            : int'($urandom_range((1 << KEY_W) - 1));
            clr = ($urandom_range(99) < 3) ? 1 : 0;
            rl  = ($urandom_range(99) < 6) ? 1 : 0;
            rs  = ($urandom_range(999) < 5) ? 1 : 0;
            cycle(bv[0], bc, clr[0], rl[0], rs[0]);
        end

        idle(2);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
